// File: rtl/count_seq_monitor.sv
// rtl/count_seq_monitor.sv - down-counter sequence monitor: lock, break detection, wrap counting
module count_seq_monitor #(
  parameter int LOCK_N = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        count_in,
  input  logic              clr_err,
  output logic              locked,
  output logic              seq_err,
  output logic              err_sticky,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED, ERR} state_t;

  localparam logic [3:0] LOCK_V = 4'(LOCK_N);

  state_t            state, state_n;
  logic [2:0]        prev;
  logic [2:0]        prev_dec;
  logic [3:0]        run, run_n;
  logic              step_ok;
  logic              seq_err_n;
  logic              wrap_pulse_n;
  logic [WRAP_W-1:0] wrap_cnt_n;

  // 3-bit subtraction gives the mod-8 expectation, so prev == 0 expects 7
  assign prev_dec = prev - 3'd1;
  assign step_ok  = (count_in == prev_dec);

  assign locked     = (state == LOCKED);
  assign err_sticky = (state == ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= 3'd0;
      run        <= 4'd0;
      seq_err    <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
    end else begin
      state      <= state_n;
      prev       <= count_in;
      run        <= run_n;
      seq_err    <= seq_err_n;
      wrap_pulse <= wrap_pulse_n;
      wrap_cnt   <= wrap_cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    run_n        = run;
    seq_err_n    = 1'b0;
    wrap_pulse_n = 1'b0;
    wrap_cnt_n   = wrap_cnt;
    case (state)
      IDLE: begin
        state_n = ACQ;
        run_n   = 4'd0;
      end
      ACQ: begin
        if (step_ok) begin
          if (run + 4'd1 == LOCK_V) begin
            state_n = LOCKED;
            run_n   = 4'd0;
          end else begin
            run_n = run + 4'd1;
          end
        end else begin
          run_n = 4'd0;
        end
      end
      LOCKED: begin
        // a bad step outranks clr_err, which has no meaning here
        if (!step_ok) begin
          state_n   = ERR;
          seq_err_n = 1'b1;
        end else if (prev == 3'd0) begin
          wrap_pulse_n = 1'b1;
          if (wrap_cnt != '1) wrap_cnt_n = wrap_cnt + 1'b1;
        end
      end
      ERR: begin
        if (clr_err) begin
          state_n = ACQ;
          run_n   = 4'd0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_count_seq_monitor.sv
// tb/tb_count_seq_monitor.sv - self-checking bench for count_seq_monitor
module tb_count_seq_monitor;

  localparam int LOCK_N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] count_in = 3'd0;
  logic       clr_err = 1'b0;

  logic       locked, seq_err, err_sticky, wrap_pulse;
  logic [7:0] wrap_cnt;
  logic       locked2, seq_err2, err_sticky2, wrap_pulse2;
  logic [1:0] wrap_cnt2;

  int total  = 0;
  int passed = 0;
  int cyc_no = 0;

  always #5 clk = ~clk;

  count_seq_monitor #(.LOCK_N(LOCK_N), .WRAP_W(8)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .clr_err(clr_err),
    .locked(locked), .seq_err(seq_err), .err_sticky(err_sticky),
    .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt)
  );

  count_seq_monitor #(.LOCK_N(LOCK_N), .WRAP_W(2)) dut2 (
    .clk(clk), .rst(rst), .count_in(count_in), .clr_err(clr_err),
    .locked(locked2), .seq_err(seq_err2), .err_sticky(err_sticky2),
    .wrap_pulse(wrap_pulse2), .wrap_cnt(wrap_cnt2)
  );

  // Reference model: mode 0 idle, 1 acquiring, 2 locked, 3 error
  int m_mode   = 0;
  int m_prev   = 0;
  int m_streak = 0;
  int m_wraps  = 0;
  bit m_seq    = 0;
  bit m_wp     = 0;

  function automatic void model_step(input bit r, input int c, input bit e);
    bit good;
    m_seq = 0;
    m_wp  = 0;
    if (r) begin
      m_mode = 0; m_prev = 0; m_streak = 0; m_wraps = 0;
      return;
    end
    good = (c == (m_prev + 7) % 8);
    case (m_mode)
      0: begin m_mode = 1; m_streak = 0; end
      1: begin
        m_streak = good ? m_streak + 1 : 0;
        if (m_streak >= LOCK_N) m_mode = 2;
      end
      2: begin
        if (!good) begin m_mode = 3; m_seq = 1; end
        else if (c == 7) begin m_wp = 1; m_wraps++; end
      end
      default: if (e) begin m_mode = 1; m_streak = 0; end
    endcase
    m_prev = c;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp)
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc_no, act, exp);
    else
      passed++;
  endtask

  task automatic cyc(input bit r, input int c, input bit e);
    rst = r; count_in = 3'(c); clr_err = e;
    @(posedge clk);
    cyc_no++;
    model_step(r, c, e);
    #1;
    chk("locked",     int'(locked),     int'(m_mode == 2));
    chk("err_sticky", int'(err_sticky), int'(m_mode == 3));
    chk("seq_err",    int'(seq_err),    int'(m_seq));
    chk("wrap_pulse", int'(wrap_pulse), int'(m_wp));
    chk("wrap_cnt",   int'(wrap_cnt),   (m_wraps > 255) ? 255 : m_wraps);
    chk("wrap_cnt_w2", int'(wrap_cnt2), (m_wraps > 3) ? 3 : m_wraps);
    chk("locked_w2",  int'(locked2),    int'(m_mode == 2));
  endtask

  typedef struct {
    bit       r;
    bit [2:0] c;
    bit       e;
    bit       lk;
    bit       se;
    bit       es;
    bit       wp;
  } vec_t;

  function automatic vec_t mk(bit r, bit [2:0] c, bit e, bit lk, bit se, bit es, bit wp);
    vec_t v;
    v.r = r; v.c = c; v.e = e; v.lk = lk; v.se = se; v.es = es; v.wp = wp;
    return v;
  endfunction

  vec_t tbl[18];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v;
    int start_cnt;
    int last_wp;
    int n_wp;

    // reset, lock latency, bad step beating clr_err, recovery and a first wrap
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 7, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 6, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 5, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 4, 0, 1, 0, 0, 0);
    tbl[7]  = mk(0, 3, 0, 1, 0, 0, 0);
    tbl[8]  = mk(0, 2, 1, 1, 0, 0, 0);
    tbl[9]  = mk(0, 0, 1, 0, 1, 1, 0);
    tbl[10] = mk(0, 5, 0, 0, 0, 1, 0);
    tbl[11] = mk(0, 4, 1, 0, 0, 0, 0);
    tbl[12] = mk(0, 3, 0, 0, 0, 0, 0);
    tbl[13] = mk(0, 2, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 1, 0, 0, 0, 0, 0);
    tbl[15] = mk(0, 0, 0, 1, 0, 0, 0);
    tbl[16] = mk(0, 7, 0, 1, 0, 0, 1);
    tbl[17] = mk(0, 6, 0, 1, 0, 0, 0);

    #1;
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].r, int'(tbl[i].c), tbl[i].e);
      chk("tbl_locked",     int'(locked),     int'(tbl[i].lk));
      chk("tbl_seq_err",    int'(seq_err),    int'(tbl[i].se));
      chk("tbl_err_sticky", int'(err_sticky), int'(tbl[i].es));
      chk("tbl_wrap_pulse", int'(wrap_pulse), int'(tbl[i].wp));
    end
    chk("tbl_wrap_cnt", int'(wrap_cnt), 1);

    // free-running while locked: wraps every 8 cycles, WRAP_W=2 copy saturates
    start_cnt = int'(wrap_cnt);
    v = 6;
    last_wp = -1;
    n_wp = 0;
    for (int i = 0; i < 40; i++) begin
      v = (v + 7) % 8;
      cyc(0, v, 0);
      if (wrap_pulse) begin
        if (last_wp >= 0) chk("wrap_gap", i - last_wp, 8);
        last_wp = i;
        n_wp++;
      end
    end
    chk("wrap_count_run", n_wp, 5);
    chk("wrap_cnt_total", int'(wrap_cnt), start_cnt + 5);
    chk("wrap_cnt_sat", int'(wrap_cnt2), 3);

    // reset mid-run clears everything, relock takes 5 edges
    cyc(1, (v + 7) % 8, 1);
    chk("rst_locked", int'(locked), 0);
    chk("rst_wrap_cnt", int'(wrap_cnt), 0);
    chk("rst_wrap_cnt_w2", int'(wrap_cnt2), 0);
    chk("rst_err", int'(err_sticky | seq_err | wrap_pulse), 0);
    v = 0;
    for (int i = 1; i <= 5; i++) begin
      cyc(0, v, 0);
      chk("relock_edge", int'(locked), (i == 5) ? 1 : 0);
      v = (v + 7) % 8;
    end

    // acquire broken after 3 good steps: no error, lock 4 good edges later
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 7, 0);
    cyc(0, 6, 0);
    cyc(0, 5, 0);
    cyc(0, 2, 0);
    chk("acq_bad_seq_err", int'(seq_err | err_sticky), 0);
    v = 2;
    for (int i = 1; i <= 4; i++) begin
      v = (v + 7) % 8;
      cyc(0, v, 0);
      chk("acq_relock", int'(locked), (i == 4) ? 1 : 0);
    end

    // randomized: mostly clean counting with glitches, clr_err and rare resets
    for (int i = 0; i < 3000; i++) begin
      bit r, e;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 15) == 0);
      if (r) v = 0;
      else if ($urandom_range(0, 29) == 0) v = int'($urandom_range(0, 7));
      else v = (v + 7) % 8;
      cyc(r, v, e);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/count_seq_monitor.md
# count_seq_monitor

Downstream consumer of the 3-bit synchronous down counter. Samples the counter's `count` bus every clock and checks that it steps by exactly −1 modulo 8. It acquires lock after a run of correct steps and flags any sequence break once locked. While locked it emits a one-cycle pulse on each terminal-count wrap (0→7) and keeps a saturating count of those wraps. It shares clock and reset with the counter and is the first observer of its output.

## Interface

Parameters:
- `LOCK_N`, default 4: number of consecutive correct steps needed to enter LOCKED. Legal range 1..15.
- `WRAP_W`, default 8: width of `wrap_cnt`.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `count_in`, input, 3: counter value, driven directly from the down counter's `count[2:0]`.
- `clr_err`, input, 1: leaves the ERR state. Sampled on the rising edge.
- `locked`, output, 1: high while the FSM is in LOCKED.
- `seq_err`, output, 1: one-cycle pulse on the edge that takes the FSM from LOCKED to ERR.
- `err_sticky`, output, 1: high while the FSM is in ERR.
- `wrap_pulse`, output, 1: one-cycle pulse per wrap detected while locked.
- `wrap_cnt`, output, `WRAP_W`: number of wraps seen while locked; saturates at all-ones.

## Operation

- Internal state:
  - `prev[2:0]`: last sampled `count_in`.
  - `run[3:0]`: consecutive-good-step counter.
  - FSM with states IDLE, ACQ, LOCKED, ERR.
- Step check: `step_ok = (count_in == prev - 3'd1)`, computed mod 8, so `prev = 0` expects 7.
- `prev <= count_in` on every non-reset edge, in every state.
- Reset (`rst` high at an edge):
  - FSM goes to IDLE; `prev`, `run`, `wrap_cnt` clear to 0.
  - All outputs are 0.
  - Reset overrides every other input, including mid-acquire and mid-error.
- IDLE: at the next non-reset edge, capture `prev` only, then go to ACQ. No step check is done in IDLE.
- ACQ:
  - `step_ok`: `run <= run + 1`. If `run + 1 == LOCK_N`, go to LOCKED and clear `run`.
  - not `step_ok`: `run <= 0` and stay in ACQ. No error is flagged during ACQ.
  - `clr_err` is ignored.
- LOCKED:
  - not `step_ok`: go to ERR and assert `seq_err` for one cycle.
  - `step_ok` with `prev == 0` and `count_in == 7`: assert `wrap_pulse` for one cycle and increment `wrap_cnt`, saturating at 2^`WRAP_W`−1.
  - `clr_err` is ignored.
- ERR:
  - `err_sticky` is high; `locked` is low; no wraps are counted.
  - `clr_err` high at an edge: go to ACQ with `run <= 0`. `prev` still updates on that edge.
  - `wrap_cnt` keeps its value; only `rst` clears it.
- Simultaneous events:
  - A bad step on the same edge as `clr_err` while in LOCKED: the bad step wins (go to ERR, pulse `seq_err`).
  - `rst` together with anything: `rst` wins.
- Counter held in reset by the shared `rst`: `count_in` stays 0 and the monitor stays in IDLE. No false error occurs at reset release.

## Timing

- All outputs are registered. A flag reflects the `count_in` sample from the edge at which it is set, and is visible for the whole following cycle.
- Lock latency from reset release, with the counter running:
  - edge 1 (first edge with `rst` low): capture.
  - edges 2..`LOCK_N`+1: good steps.
  - `locked` rises after edge `LOCK_N`+1 (edge 5 with the default).
- Error latency: `seq_err` and `err_sticky` rise after the edge that samples the bad value. `locked` falls on that same edge.
- Wrap latency: `wrap_pulse` is high for the cycle after the edge that samples 7 following 0. `wrap_cnt` updates on that same edge.
- Recovery: after `clr_err`, at least `LOCK_N` more good edges are needed before `locked` rises again.
- Free-running counter: with the default parameters, one wrap occurs every 8 cycles once locked.

## Test plan

- Reset release with the counter free-running (0,7,6,…), `LOCK_N = 4` → `locked = 0` through edge 4, `locked = 1` after edge 5; `seq_err` stays 0.
- Locked, monitor run for 24 more cycles → exactly 3 `wrap_pulse`s, each one cycle wide and 8 cycles apart; `wrap_cnt = 3`.
- Locked, force `count_in` to skip (5→3) → `seq_err` pulses once, `err_sticky = 1`, `locked = 0`. Later skips produce no further `seq_err`, and `wrap_cnt` stays frozen.
- In ERR, pulse `clr_err` for one cycle with a clean sequence → `err_sticky` falls next cycle, `locked` returns 4 edges later, `wrap_cnt` is preserved.
- During ACQ, inject one bad value after 3 good steps → `run` resets, no `seq_err`, and `locked` appears only 4 good edges after the bad sample.
- `WRAP_W = 2`, run 5 wraps while locked → `wrap_cnt` saturates at 3. Then assert `rst` mid-run → all outputs 0 after that edge, and relock occurs after 5 edges.
